cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Instruction-cycle controller for the 8-bit CPU core. It sequences each 2-byte instruction through an 8-state fetch/execute cycle and drives PC, IR, accumulator, ALU and bus-control enables, plus the `fetch` strobe that steers the address mux between PC and the IR operand field. It sits inside `cpu` between the instruction register / ALU zero flag and the shared RAM/ROM bus strobes. It adds halt handling and a single-step debug mode.

## Interface
- `STEP_SYNC`, default 1. 1 = `step` passes through a 2-flop synchronizer before edge detection. 0 = `step` is already synchronous to `clk`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `opcode`  in  3  IR[15:13]; valid from T1 onward.
- `zero`  in  1  accumulator == 0 flag.
- `step_en`  in  1  1 = single-step mode.
- `step`  in  1  each rising edge releases one instruction in step mode.
- `fetch`  out  1  1 in T0–T3; address mux selects PC.
- `rd`  out  1  bus read strobe.
- `wr`  out  1  bus write strobe.
- `load_ir`  out  1  load IR byte from the data bus.
- `inc_pc`  out  1  PC += 1.
- `load_pc`  out  1  PC <= IR[12:0].
- `alu_ena`  out  1  ALU computes on its operands.
- `load_acc`  out  1  accumulator <= ALU result.
- `datactl_ena`  out  1  drive the accumulator onto the data bus.
- `halt`  out  1  CPU halted.
- `waiting`  out  1  parked in WAIT (step mode).

## Operation
- States: IDLE, T0–T7, WAIT, HALTED. Encodings live in `cpu_pkg`.
- All outputs are a combinational decode of the state register and the latched `opc_q`/`zero_q`. No output is active outside its listed states.
- IDLE:
  - All outputs are 0.
  - Next state is T0, or WAIT if `step_en`=1.
- T0: `rd`, `load_ir` (high byte).
- T1: `inc_pc`.
- T2: `rd`, `load_ir` (low byte).
- T3: `inc_pc`. At the T3 exit edge:
  - `opc_q` <= `opcode` and `zero_q` <= `zero`.
  - If `opcode`=HLT, go to HALTED; otherwise go to T4.
- T4:
  - ADD/AND/XOR/LDA: `rd`.
  - STO: `datactl_ena`.
  - JMP: `load_pc`.
  - SKZ with `zero_q`=1: `inc_pc`.
- T5:
  - ADD/AND/XOR/LDA: `rd`, `alu_ena`.
  - STO: `datactl_ena`, `wr`.
- T6:
  - ADD/AND/XOR/LDA: `rd`, `load_acc`.
  - STO: `datactl_ena`.
  - SKZ with `zero_q`=1: `inc_pc`. A skip therefore advances PC by 2, one full instruction.
- T7:
  - No strobes.
  - Next state is T0, or WAIT if `step_en`=1 at the T7 exit edge.
- WAIT:
  - `waiting`=1; all other outputs 0.
  - On a detected `step` rising edge, go to T0.
  - If `step_en` drops to 0, go to T0 on the next edge with no step needed.
- HALTED:
  - `halt`=1; all other outputs 0.
  - Leaves only via reset. `step` is ignored.
- `step_en` changes mid-instruction take effect only at the T7 (or IDLE) exit.
- Opcode 3'b000 is HLT. Undefined decode is impossible, since all 8 opcodes are defined.

## Timing
- Reset assertion forces IDLE immediately, with all outputs 0:
  - `opc_q`=0, `zero_q`=0, synchronizer and edge-detect flops = 0.
  - Reset mid-instruction aborts the instruction with no further strobes.
- First T0 occurs on the 2nd rising `clk` edge after `reset` deasserts (IDLE lasts one cycle).
- Free-running mode: exactly 8 cycles per instruction. `fetch` is high 4 cycles, low 4 cycles.
- `halt` rises one cycle after T3 of the HLT instruction, i.e. the 5th cycle of that instruction.
- Step latency:
  - `STEP_SYNC`=1: T0 begins 3 cycles after `step` is first sampled high.
  - `STEP_SYNC`=0: T0 begins 1 cycle after.
- A `step` held high releases exactly one instruction. A new instruction needs a low-then-high transition.
- A `step` edge arriving while not in WAIT is discarded. It is not queued.

## Structure
- `cpu_pkg` holds:
  - opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7;
  - the state enum;
  - `CYCLES_PER_INSTR`=8.
- Sub-module `step_sync` contains the optional 2-flop synchronizer and the rising-edge detector, and outputs a 1-cycle `step_pulse`.

## Test plan
- **Reset and free run:** reset low 70 ns, release; opcode=ADD, `step_en`=0 → IDLE 1 cycle, then `fetch` pattern 1111_0000 repeating; `rd` in T0, T2, T4, T5, T6; `load_acc` only in T6; `inc_pc` 2 per instruction.
- **Skip on zero:** SKZ with `zero`=1 → 4 `inc_pc` pulses per instruction. SKZ with `zero`=0 → 2 pulses. `zero` toggled during T5 has no effect.
- **STO and JMP:** STO → `datactl_ena` T4–T6 and `wr` in T5 only, with `rd`=0 in T4–T7. JMP → `load_pc` in T4 only.
- **Halt:** opcode=HLT → `halt`=1 from the cycle after T3 and held for 100 cycles with all strobes 0. `step` pulses are ignored. `reset` low returns to IDLE with `halt`=0.
- **Single step:** `step_en`=1 → `waiting`=1 after IDLE. A `step` held high for 20 cycles yields exactly one instruction and then a return to WAIT. With `STEP_SYNC`=1, T0 begins 3 cycles after `step` rises.
- **Reset mid-execute:** assert `reset` during T5 of STO → `wr` and `datactl_ena` drop asynchronously within the same cycle; after release, the sequence restarts at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU core: opcodes, sequencer states,
// and instruction-length parameter.
package cpu_pkg;

  localparam int unsigned CYCLES_PER_INSTR = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_WAIT   = 4'd9,
    S_HALTED = 4'd10
  } state_e;

  // Opcodes that read memory into the accumulator path during T4-T6.
  function automatic logic is_acc_op(input opcode_e op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/step_sync.sv
// Single-step input conditioning: optional 2-flop synchronizer followed by a
// rising-edge detector producing a one-cycle step_pulse.
module step_sync #(
  parameter bit STEP_SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic step_pulse
);

  logic src;
  logic prev_q, prev_d;

  if (STEP_SYNC) begin : g_sync
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], step};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign src = sync_q[1];
  end else begin : g_nosync
    assign src = step;
  end

  always_comb prev_d = src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign step_pulse = src & ~prev_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: 8-state fetch/execute sequence per 2-byte
// instruction, with halt handling and single-step debug parking in WAIT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter bit STEP_SYNC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       step_en,
  input  logic       step,
  output logic       fetch,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       alu_ena,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic       waiting
);

  state_e  state_q, state_d;
  opcode_e opc_q, opc_d;
  logic    zero_q, zero_d;
  logic    run_q, run_d;
  logic    step_pulse;

  step_sync #(
    .STEP_SYNC(STEP_SYNC)
  ) u_step_sync (
    .clk       (clk),
    .rst_n     (reset),
    .step      (step),
    .step_pulse(step_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opc_q   <= HLT;
      zero_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      zero_q  <= zero_d;
      run_q   <= run_d;
    end
  end

  // run_q holds IDLE for the first full cycle after reset release.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    zero_d  = zero_q;
    run_d   = 1'b1;
    unique case (state_q)
      S_IDLE: if (run_q) state_d = step_en ? S_WAIT : S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        opc_d   = opcode_e'(opcode);
        zero_d  = zero;
        state_d = (opcode_e'(opcode) == HLT) ? S_HALTED : S_T4;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = step_en ? S_WAIT : S_T0;
      S_WAIT: if (!step_en || step_pulse) state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch       = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    alu_ena     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    waiting     = 1'b0;
    unique case (state_q)
      S_T0, S_T2: begin
        fetch   = 1'b1;
        rd      = 1'b1;
        load_ir = 1'b1;
      end
      S_T1, S_T3: begin
        fetch  = 1'b1;
        inc_pc = 1'b1;
      end
      S_T4: begin
        if (is_acc_op(opc_q))           rd          = 1'b1;
        else if (opc_q == STO)          datactl_ena = 1'b1;
        else if (opc_q == JMP)          load_pc     = 1'b1;
        else if (opc_q == SKZ && zero_q) inc_pc     = 1'b1;
      end
      S_T5: begin
        if (is_acc_op(opc_q)) begin
          rd      = 1'b1;
          alu_ena = 1'b1;
        end else if (opc_q == STO) begin
          datactl_ena = 1'b1;
          wr          = 1'b1;
        end
      end
      S_T6: begin
        if (is_acc_op(opc_q)) begin
          rd       = 1'b1;
          load_acc = 1'b1;
        end else if (opc_q == STO) begin
          datactl_ena = 1'b1;
        end else if (opc_q == SKZ && zero_q) begin
          inc_pc = 1'b1;
        end
      end
      S_WAIT:   waiting = 1'b1;
      S_HALTED: halt    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues hand-computed output
// vectors per cycle, a monitor pops and compares them at the falling edge.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       step_en;
  logic       step;
  logic       fetch, rd, wr, load_ir, inc_pc, load_pc;
  logic       alu_ena, load_acc, datactl_ena, halt, waiting;

  cpu_sequencer #(
    .STEP_SYNC(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .step_en    (step_en),
    .step       (step),
    .fetch      (fetch),
    .rd         (rd),
    .wr         (wr),
    .load_ir    (load_ir),
    .inc_pc     (inc_pc),
    .load_pc    (load_pc),
    .alu_ena    (alu_ena),
    .load_acc   (load_acc),
    .datactl_ena(datactl_ena),
    .halt       (halt),
    .waiting    (waiting)
  );

  // {fetch, rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt, waiting}
  localparam logic [10:0] O_F    = 11'h400;
  localparam logic [10:0] O_RD   = 11'h200;
  localparam logic [10:0] O_WR   = 11'h100;
  localparam logic [10:0] O_LIR  = 11'h080;
  localparam logic [10:0] O_INC  = 11'h040;
  localparam logic [10:0] O_LPC  = 11'h020;
  localparam logic [10:0] O_ALU  = 11'h010;
  localparam logic [10:0] O_LACC = 11'h008;
  localparam logic [10:0] O_DCT  = 11'h004;
  localparam logic [10:0] O_HLT  = 11'h002;
  localparam logic [10:0] O_WAIT = 11'h001;
  localparam logic [10:0] FT0    = O_F | O_RD | O_LIR;
  localparam logic [10:0] FT1    = O_F | O_INC;

  typedef struct {
    logic [10:0] vec;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {fetch, rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc,
               datactl_ena, halt, waiting};
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL %s got %b want %b at %0t", e.nm, act, e.vec, $time);
        end
      end
    end
  end

  task automatic push(input logic [10:0] v, input string nm);
    exp_q.push_back('{v, nm});
  endtask

  task automatic cyc(input logic [10:0] v, input string nm);
    @(posedge clk);
    #1;
    push(v, nm);
  endtask

  // One full instruction; opcode/zero applied in T0, zero flipped in T5,
  // step_en applied in T2, optional step low/high mid-instruction.
  task automatic run_instr(input logic [2:0] opc, input logic z,
                           input logic [10:0] t4, input logic [10:0] t5,
                           input logic [10:0] t6, input logic sen,
                           input logic pulse_mid, input string nm);
    cyc(FT0, {nm, " T0"}); opcode = opc; zero = z;
    cyc(FT1, {nm, " T1"}); if (pulse_mid) step = 1'b0;
    cyc(FT0, {nm, " T2"}); step_en = sen;
    cyc(FT1, {nm, " T3"}); if (pulse_mid) step = 1'b1;
    cyc(t4,  {nm, " T4"});
    cyc(t5,  {nm, " T5"}); zero = ~zero;
    cyc(t6,  {nm, " T6"});
    cyc('0,  {nm, " T7"});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    opcode  = ADD;
    zero    = 1'b0;
    step_en = 1'b0;
    step    = 1'b0;

    for (int i = 0; i < 6; i++) cyc('0, "reset");
    #14 reset = 1'b1;
    cyc('0, "idle");

    run_instr(ADD, 1'b0, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b0, 1'b0, "add1");
    run_instr(AND, 1'b0, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b0, 1'b0, "and");
    run_instr(SKZ, 1'b1, O_INC, '0, O_INC, 1'b0, 1'b0, "skz_z1");
    run_instr(SKZ, 1'b0, '0, '0, '0, 1'b0, 1'b0, "skz_z0");
    run_instr(STO, 1'b0, O_DCT, O_DCT | O_WR, O_DCT, 1'b0, 1'b0, "sto");
    run_instr(JMP, 1'b0, O_LPC, '0, '0, 1'b0, 1'b0, "jmp");
    run_instr(XOR, 1'b1, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b1, 1'b0, "xor");

    for (int i = 0; i < 3; i++) cyc(O_WAIT, "wait_a");
    step = 1'b1;
    cyc(O_WAIT, "wait_sync1");
    cyc(O_WAIT, "wait_sync2");
    run_instr(LDA, 1'b0, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b1, 1'b0, "lda_step");
    for (int i = 0; i < 10; i++) cyc(O_WAIT, "wait_held");
    step = 1'b0;
    for (int i = 0; i < 3; i++) cyc(O_WAIT, "wait_low");
    step = 1'b1;
    cyc(O_WAIT, "wait_sync1b");
    cyc(O_WAIT, "wait_sync2b");
    run_instr(ADD, 1'b0, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b1, 1'b1, "add_step");
    for (int i = 0; i < 4; i++) cyc(O_WAIT, "wait_discard");
    step_en = 1'b0;
    run_instr(AND, 1'b0, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b0, 1'b0, "and_free");

    cyc(FT0, "hlt T0"); opcode = HLT; step = 1'b0;
    cyc(FT1, "hlt T1");
    cyc(FT0, "hlt T2");
    cyc(FT1, "hlt T3");
    for (int i = 0; i < 100; i++) begin
      cyc(O_HLT, "halted");
      if (i % 5 == 4) step = ~step;
    end

    @(posedge clk);
    #1;
    reset = 1'b0;
    push('0, "halt_reset");
    step = 1'b0; opcode = STO; zero = 1'b0;
    cyc('0, "reset2");
    reset = 1'b1;
    cyc('0, "idle2");

    cyc(FT0, "sto2 T0");
    cyc(FT1, "sto2 T1");
    cyc(FT0, "sto2 T2");
    cyc(FT1, "sto2 T3");
    cyc(O_DCT, "sto2 T4");
    cyc(O_DCT | O_WR, "sto2 T5");
    #6 reset = 1'b0;
    #1;
    push('0, "mid_reset");
    -> sample_ev;
    cyc('0, "reset3");
    reset = 1'b1;
    cyc('0, "idle3");
    run_instr(STO, 1'b0, O_DCT, O_DCT | O_WR, O_DCT, 1'b0, 1'b0, "sto3");
    run_instr(ADD, 1'b0, O_RD, O_RD | O_ALU, O_RD | O_LACC, 1'b0, 1'b0, "add3");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
